// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory port: load/store size codes and the
// DMA handshake state encoding.
package dm_pkg;

    localparam logic [1:0] WORD = 2'b00;
    localparam logic [1:0] HALF = 2'b01;
    localparam logic [1:0] BYTE = 2'b10;

    typedef enum logic {
        D_IDLE = 1'b0,
        D_ACK  = 1'b1
    } dstate_t;

endpackage

// File: rtl/dm_arbiter_if.sv
// Bundle of the CPU, DMA and memory-side signals around the data-memory arbiter.
// slave is the arbiter's view; master is the requestor/memory view.
interface dm_arbiter_if;

    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [1:0]  cpu_ls_bit;
    logic        cpu_ext_op;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;

    logic        dma_req;
    logic        dma_we;
    logic [31:0] dma_addr;
    logic [31:0] dma_wdata;
    logic [1:0]  dma_ls_bit;
    logic        dma_ext_op;
    logic        dma_ack;
    logic        dma_err;
    logic [31:0] dma_rdata;

    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [1:0]  dm_ls_bit;
    logic        dm_we;
    logic        dm_ext_op;
    logic [31:0] dm_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_ls_bit, cpu_ext_op,
        output cpu_rdata, cpu_stall,
        input  dma_req, dma_we, dma_addr, dma_wdata, dma_ls_bit, dma_ext_op,
        output dma_ack, dma_err, dma_rdata,
        output dm_addr, dm_wdata, dm_ls_bit, dm_we, dm_ext_op,
        input  dm_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_ls_bit, cpu_ext_op,
        input  cpu_rdata, cpu_stall,
        output dma_req, dma_we, dma_addr, dma_wdata, dma_ls_bit, dma_ext_op,
        input  dma_ack, dma_err, dma_rdata,
        input  dm_addr, dm_wdata, dm_ls_bit, dm_we, dm_ext_op,
        output dm_rdata
    );

endinterface

// File: rtl/dm_align_chk.sv
// Flags accesses whose address is not aligned to the requested size, plus the
// reserved size code 2'b11.
module dm_align_chk
    import dm_pkg::*;
(
    input  logic [1:0] addr_lo,
    input  logic [1:0] ls_bit,
    output logic       misalign
);

    always_comb begin
        misalign = 1'b0;
        unique case (ls_bit)
            WORD:    misalign = (addr_lo != 2'b00);
            HALF:    misalign = addr_lo[0];
            BYTE:    misalign = 1'b0;
            default: misalign = 1'b1;
        endcase
    end

endmodule

// File: rtl/dm_arbiter.sv
// Shares the data-memory port between the MEM stage (fixed priority) and a
// DMA/loader port, with a starvation counter that forces periodic DMA grants.
module dm_arbiter
    import dm_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 3
) (
    input logic         clock,
    input logic         reset_n,
    dm_arbiter_if.slave bus
);

    localparam logic [CNT_W-1:0] StarveMax = CNT_W'(STARVE_LIMIT);

    dstate_t          dstate_q, dstate_d;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic             dma_ack_q, dma_ack_d;
    logic             dma_err_q, dma_err_d;
    logic [31:0]      dma_rdata_q, dma_rdata_d;

    logic dma_ok;
    logic grant_dma;
    logic grant_cpu;
    logic misalign;

    dm_align_chk u_align_chk (
        .addr_lo  (bus.dma_addr[1:0]),
        .ls_bit   (bus.dma_ls_bit),
        .misalign (misalign)
    );

    // D_ACK blocks a new grant so a held request is never issued twice.
    assign dma_ok    = (dstate_q == D_IDLE) & bus.dma_req;
    assign grant_dma = dma_ok & (~bus.cpu_req | (starve_cnt_q == StarveMax));
    assign grant_cpu = bus.cpu_req & ~grant_dma;

    assign bus.cpu_stall = bus.cpu_req & grant_dma;
    assign bus.cpu_rdata = grant_cpu ? bus.dm_rdata : 32'h0;
    assign bus.dma_ack   = dma_ack_q;
    assign bus.dma_err   = dma_err_q;
    assign bus.dma_rdata = dma_rdata_q;

    always_comb begin
        bus.dm_addr   = 32'h0;
        bus.dm_wdata  = 32'h0;
        bus.dm_ls_bit = WORD;
        bus.dm_we     = 1'b0;
        bus.dm_ext_op = 1'b0;
        if (grant_cpu) begin
            bus.dm_addr   = bus.cpu_addr;
            bus.dm_wdata  = bus.cpu_wdata;
            bus.dm_ls_bit = bus.cpu_ls_bit;
            bus.dm_we     = bus.cpu_we;
            bus.dm_ext_op = bus.cpu_ext_op;
        end else if (grant_dma) begin
            bus.dm_addr   = bus.dma_addr;
            bus.dm_wdata  = bus.dma_wdata;
            bus.dm_ls_bit = bus.dma_ls_bit;
            bus.dm_we     = bus.dma_we & ~misalign;
            bus.dm_ext_op = bus.dma_ext_op;
        end
    end

    always_comb begin
        dstate_d     = dstate_q;
        starve_cnt_d = starve_cnt_q;
        dma_ack_d    = 1'b0;
        dma_err_d    = dma_err_q;
        dma_rdata_d  = dma_rdata_q;

        if (grant_dma || !bus.dma_req) begin
            starve_cnt_d = '0;
        end else if (dma_ok && bus.cpu_req && starve_cnt_q != StarveMax) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end

        unique case (dstate_q)
            D_IDLE: begin
                if (grant_dma) begin
                    dstate_d    = D_ACK;
                    dma_ack_d   = 1'b1;
                    dma_err_d   = misalign;
                    dma_rdata_d = bus.dma_we ? 32'h0 : bus.dm_rdata;
                end
            end
            D_ACK:   dstate_d = D_IDLE;
            default: dstate_d = D_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dstate_q     <= D_IDLE;
            starve_cnt_q <= '0;
            dma_ack_q    <= 1'b0;
            dma_err_q    <= 1'b0;
            dma_rdata_q  <= 32'h0;
        end else begin
            dstate_q     <= dstate_d;
            starve_cnt_q <= starve_cnt_d;
            dma_ack_q    <= dma_ack_d;
            dma_err_q    <= dma_err_d;
            dma_rdata_q  <= dma_rdata_d;
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: directed scenarios plus a randomized run
// against a cycle-level behavioural model of the arbitration rules.
module tb_dm_arbiter;
    import dm_pkg::*;

    localparam int LIMIT = 4;

    logic clock;
    logic reset_n;
    int   n_cmp;
    int   n_err;

    logic [31:0] mem [0:1023];

    dm_arbiter_if bus ();

    dm_arbiter #(
        .STARVE_LIMIT (LIMIT),
        .CNT_W        (3)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory model: combinational read, write on the falling edge.
    assign bus.dm_rdata = mem[bus.dm_addr[11:2]];

    always @(negedge clock) begin
        if (bus.dm_we) begin
            case (bus.dm_ls_bit)
                WORD: mem[bus.dm_addr[11:2]] = bus.dm_wdata;
                HALF: begin
                    if (bus.dm_addr[1]) mem[bus.dm_addr[11:2]][31:16] = bus.dm_wdata[15:0];
                    else                mem[bus.dm_addr[11:2]][15:0]  = bus.dm_wdata[15:0];
                end
                default: mem[bus.dm_addr[11:2]][8*bus.dm_addr[1:0] +: 8] = bus.dm_wdata[7:0];
            endcase
        end
    end

    function automatic bit bad_access(input logic [1:0] ls, input logic [31:0] a);
        case (ls)
            2'b00:   return (a % 4) != 0;
            2'b01:   return (a % 2) != 0;
            2'b10:   return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
        bus.cpu_ls_bit = WORD; bus.cpu_ext_op = 0;
        bus.dma_req = 0; bus.dma_we = 0; bus.dma_addr = 0; bus.dma_wdata = 0;
        bus.dma_ls_bit = WORD; bus.dma_ext_op = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 0;
        repeat (3) @(posedge clock);
        #1 reset_n = 1;
        next_cycle();
        #3;
        if ({bus.dm_addr, bus.dm_wdata, bus.dm_ls_bit, bus.dm_we, bus.dm_ext_op} !== 68'h0) begin
            $display("FAIL reset_dm: got %h required 0",
                     {bus.dm_addr, bus.dm_wdata, bus.dm_ls_bit, bus.dm_we, bus.dm_ext_op});
            n_err++;
        end
        n_cmp++;
        if ({bus.cpu_stall, bus.dma_ack, bus.dma_err} !== 3'b000) begin
            $display("FAIL reset_flags: got %b required 000",
                     {bus.cpu_stall, bus.dma_ack, bus.dma_err});
            n_err++;
        end
        n_cmp++;
        if (bus.dma_rdata !== 32'h0 || bus.cpu_rdata !== 32'h0) begin
            $display("FAIL reset_rdata: got %h/%h required 0/0", bus.dma_rdata, bus.cpu_rdata);
            n_err++;
        end
        n_cmp++;
        next_cycle();
    endtask

    task automatic test_cpu_only();
        bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 32'h10; bus.cpu_wdata = 32'hDEADBEEF;
        #3;
        if (bus.dm_we !== 1'b1 || bus.dm_addr !== 32'h10 || bus.cpu_stall !== 1'b0) begin
            $display("FAIL cpu_store: got we=%b addr=%h stall=%b required 1/10/0",
                     bus.dm_we, bus.dm_addr, bus.cpu_stall);
            n_err++;
        end
        n_cmp++;
        next_cycle();
        bus.cpu_we = 0; bus.cpu_wdata = 0;
        #3;
        if (bus.cpu_rdata !== 32'hDEADBEEF || bus.cpu_stall !== 1'b0 || bus.dm_we !== 1'b0) begin
            $display("FAIL cpu_load: got rdata=%h stall=%b we=%b required deadbeef/0/0",
                     bus.cpu_rdata, bus.cpu_stall, bus.dm_we);
            n_err++;
        end
        n_cmp++;
        next_cycle();
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_dma_only();
        mem[1] = 32'h12345678;
        bus.dma_req = 1; bus.dma_addr = 32'h4; bus.dma_ls_bit = WORD;
        for (int c = 0; c < 4; c++) begin
            #3;
            if (bus.dma_ack !== logic'(c % 2) || bus.dm_addr !== ((c % 2) ? 32'h0 : 32'h4)) begin
                $display("FAIL dma_only_c%0d: got ack=%b addr=%h required ack=%0d",
                         c, bus.dma_ack, bus.dm_addr, c % 2);
                n_err++;
            end
            n_cmp++;
            if (c % 2 == 1) begin
                if (bus.dma_rdata !== 32'h12345678 || bus.dma_err !== 1'b0) begin
                    $display("FAIL dma_only_data%0d: got %h err=%b required 12345678 err=0",
                             c, bus.dma_rdata, bus.dma_err);
                    n_err++;
                end
                n_cmp++;
            end
            next_cycle();
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_starvation();
        mem[1] = 32'hCAFEF00D;
        bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 32'h40; bus.cpu_wdata = 32'h1;
        bus.dma_req = 1; bus.dma_addr = 32'h4; bus.dma_ls_bit = WORD;
        for (int c = 0; c < 7; c++) begin
            bit exp_stall;
            bit exp_ack;
            exp_stall = (c == 4);
            exp_ack   = (c == 5);
            #3;
            if (bus.cpu_stall !== exp_stall || bus.dma_ack !== exp_ack) begin
                $display("FAIL starve_c%0d: got stall=%b ack=%b required %b/%b",
                         c, bus.cpu_stall, bus.dma_ack, exp_stall, exp_ack);
                n_err++;
            end
            n_cmp++;
            if (bus.dm_addr !== (exp_stall ? 32'h4 : 32'h40) || bus.dm_we !== !exp_stall) begin
                $display("FAIL starve_mux_c%0d: got addr=%h we=%b", c, bus.dm_addr, bus.dm_we);
                n_err++;
            end
            n_cmp++;
            if (exp_ack && bus.dma_rdata !== 32'hCAFEF00D) begin
                $display("FAIL starve_rdata: got %h required cafef00d", bus.dma_rdata);
                n_err++;
            end
            if (exp_ack) n_cmp++;
            next_cycle();
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_misaligned();
        mem[0] = 32'hA5A5A5A5;
        bus.dma_req = 1; bus.dma_we = 1; bus.dma_addr = 32'h3; bus.dma_ls_bit = HALF;
        bus.dma_wdata = 32'h0000FFFF;
        #3;
        if (bus.dm_we !== 1'b0 || bus.dm_addr !== 32'h3) begin
            $display("FAIL misalign_we: got we=%b addr=%h required 0/3", bus.dm_we, bus.dm_addr);
            n_err++;
        end
        n_cmp++;
        next_cycle();
        bus.dma_req = 0;
        #3;
        if (bus.dma_ack !== 1'b1 || bus.dma_err !== 1'b1 || mem[0] !== 32'hA5A5A5A5) begin
            $display("FAIL misalign_ack: got ack=%b err=%b mem=%h required 1/1/a5a5a5a5",
                     bus.dma_ack, bus.dma_err, mem[0]);
            n_err++;
        end
        n_cmp++;
        next_cycle();
        bus.dma_req = 1; bus.dma_we = 0; bus.dma_addr = 32'h8; bus.dma_ls_bit = 2'b11;
        next_cycle();
        bus.dma_req = 0;
        #3;
        if (bus.dma_ack !== 1'b1 || bus.dma_err !== 1'b1) begin
            $display("FAIL ls11_err: got ack=%b err=%b required 1/1", bus.dma_ack, bus.dma_err);
            n_err++;
        end
        n_cmp++;
        next_cycle();
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_reset_mid_op();
        mem[1] = 32'h0BADC0DE;
        bus.dma_req = 1; bus.dma_addr = 32'h4; bus.dma_ls_bit = WORD;
        next_cycle();
        #1;
        if (bus.dma_ack !== 1'b1) begin
            $display("FAIL midrst_pre: got ack=%b required 1", bus.dma_ack);
            n_err++;
        end
        n_cmp++;
        reset_n = 0;
        #1;
        if (bus.dma_ack !== 1'b0 || dut.starve_cnt_q !== 3'd0) begin
            $display("FAIL midrst_async: got ack=%b cnt=%0d required 0/0",
                     bus.dma_ack, dut.starve_cnt_q);
            n_err++;
        end
        n_cmp++;
        next_cycle();
        reset_n = 1;
        #3;
        if (bus.dm_addr !== 32'h4 || bus.dma_ack !== 1'b0) begin
            $display("FAIL midrst_reissue: got addr=%h ack=%b required 4/0",
                     bus.dm_addr, bus.dma_ack);
            n_err++;
        end
        n_cmp++;
        next_cycle();
        bus.dma_req = 0;
        #3;
        if (bus.dma_ack !== 1'b1 || bus.dma_rdata !== 32'h0BADC0DE) begin
            $display("FAIL midrst_done: got ack=%b rdata=%h required 1/0badc0de",
                     bus.dma_ack, bus.dma_rdata);
            n_err++;
        end
        n_cmp++;
        next_cycle();
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_random();
        bit          in_ack;
        int          losses;
        bit          dreq_active;
        logic [31:0] cap_rdata;
        bit          cap_err;
        in_ack = 0; losses = 0; dreq_active = 0; cap_rdata = 0; cap_err = 0;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        for (int c = 0; c < 400; c++) begin
            bit          cpu_wins;
            bit          dma_wins;
            bit          eligible;
            logic [31:0] exp_addr;
            bit          exp_we;
            logic [31:0] exp_cpu_rdata;

            bus.cpu_req    = ($urandom_range(0, 3) != 0);
            bus.cpu_we     = $urandom_range(0, 1);
            bus.cpu_addr   = {20'h0, 12'($urandom_range(0, 1023) * 4)};
            bus.cpu_wdata  = $urandom;
            bus.cpu_ls_bit = WORD;
            if (in_ack) dreq_active = 0;
            else if (!dreq_active && $urandom_range(0, 2) == 0) begin
                dreq_active    = 1;
                bus.dma_we     = $urandom_range(0, 1);
                bus.dma_addr   = {20'h0, 12'($urandom_range(0, 4095))};
                bus.dma_ls_bit = 2'($urandom_range(0, 3));
                bus.dma_wdata  = $urandom;
            end
            bus.dma_req = dreq_active;

            eligible = dreq_active && !in_ack;
            dma_wins = eligible && (!bus.cpu_req || losses == LIMIT);
            cpu_wins = bus.cpu_req && !dma_wins;
            exp_addr = cpu_wins ? bus.cpu_addr : (dma_wins ? bus.dma_addr : 32'h0);
            exp_we   = cpu_wins ? bus.cpu_we
                     : (dma_wins && bus.dma_we && !bad_access(bus.dma_ls_bit, bus.dma_addr));
            #3;
            exp_cpu_rdata = cpu_wins ? mem[bus.cpu_addr[11:2]] : 32'h0;
            if (bus.cpu_stall !== (bus.cpu_req && dma_wins) || bus.dm_addr !== exp_addr
                || bus.dm_we !== exp_we || bus.cpu_rdata !== exp_cpu_rdata) begin
                $display("FAIL rand_mux_c%0d: got stall=%b addr=%h we=%b rd=%h required %b/%h/%b/%h",
                         c, bus.cpu_stall, bus.dm_addr, bus.dm_we, bus.cpu_rdata,
                         bus.cpu_req && dma_wins, exp_addr, exp_we, exp_cpu_rdata);
                n_err++;
            end
            n_cmp++;
            if (bus.dma_ack !== in_ack) begin
                $display("FAIL rand_ack_c%0d: got %b required %b", c, bus.dma_ack, in_ack);
                n_err++;
            end
            n_cmp++;
            if (in_ack) begin
                if (bus.dma_rdata !== cap_rdata || bus.dma_err !== cap_err) begin
                    $display("FAIL rand_data_c%0d: got %h err=%b required %h err=%b",
                             c, bus.dma_rdata, bus.dma_err, cap_rdata, cap_err);
                    n_err++;
                end
                n_cmp++;
            end

            if (dma_wins) begin
                cap_rdata = bus.dma_we ? 32'h0 : mem[bus.dma_addr[11:2]];
                cap_err   = bad_access(bus.dma_ls_bit, bus.dma_addr);
            end
            if (dma_wins || !dreq_active) losses = 0;
            else if (eligible && bus.cpu_req) losses++;
            in_ack = dma_wins;
            next_cycle();
        end
        idle_inputs();
        next_cycle();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        reset_n = 1;
        idle_inputs();
        #1;
        test_reset();
        test_cpu_only();
        test_dma_only();
        test_starvation();
        test_misaligned();
        test_reset_mid_op();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
